// File: rtl/saci_pkg.sv
// Shared frame geometry and FSM state encoding for the SACI slave.
package saci_pkg;

  localparam int FRAME_LEN = 53;
  localparam int CMD_W     = 7;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int PAYLOAD_W = FRAME_LEN - 1;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    REQ,
    TX,
    DONE
  } saci_state_e;

endpackage

// File: rtl/saci_sync.sv
// Multi-flop synchronizer with a selectable idle level applied on reset.
module saci_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_reg[gi] <= RST_VAL;
        end else if (gi == 0) begin
          sync_reg[gi] <= d_i;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q_o = sync_reg[STAGES-1];

endmodule

// File: rtl/saci_slave_oversampled.sv
// SACI serial slave: oversamples the master's clock with clk_i, decodes a
// 53-bit command frame into a register request and shifts back the response.
module saci_slave_oversampled
  import saci_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RSP_DELAY   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              saci_clk_i,
  input  logic              saci_sel_n_i,
  input  logic              saci_cmd_i,
  output logic              saci_rsp_o,
  output logic              req_o,
  output logic              wr_o,
  output logic [CMD_W-1:0]  cmd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o
);

  localparam int DLY_W = $clog2(RSP_DELAY + 2);

  logic sclk_s, sel_n_s, cmd_s;
  logic sclk_d_reg;
  logic rise, fall;

  saci_state_e          state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DLY_W-1:0]     dly_reg;
  logic [PAYLOAD_W-1:0] shift_reg;
  logic [FRAME_LEN-1:0] tx_reg;
  logic [PAYLOAD_W-1:0] rx_word;

  logic              req_reg, wr_reg, rsp_reg;
  logic [CMD_W-1:0]  cmd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  saci_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(saci_clk_i), .q_o(sclk_s));
  saci_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(saci_sel_n_i), .q_o(sel_n_s));
  saci_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cmd (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(saci_cmd_i), .q_o(cmd_s));

  assign rise    = sclk_s & ~sclk_d_reg;
  assign fall    = ~sclk_s & sclk_d_reg;
  assign rx_word = {shift_reg[PAYLOAD_W-2:0], cmd_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      sclk_d_reg <= 1'b0;
      cnt_reg    <= '0;
      dly_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= '0;
      req_reg    <= 1'b0;
      wr_reg     <= 1'b0;
      cmd_reg    <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rsp_reg    <= 1'b0;
    end else begin
      sclk_d_reg <= sclk_s;
      case (state_reg)
        IDLE: begin
          req_reg <= 1'b0;
          rsp_reg <= 1'b0;
          if (rise && !sel_n_s && cmd_s) begin
            cnt_reg   <= CNT_W'(PAYLOAD_W);
            state_reg <= RX;
          end
        end
        RX: begin
          if (sel_n_s) begin
            state_reg <= IDLE;
          end else if (rise) begin
            shift_reg <= rx_word;
            cnt_reg   <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
              wr_reg    <= rx_word[PAYLOAD_W-1];
              cmd_reg   <= rx_word[PAYLOAD_W-2 -: CMD_W];
              addr_reg  <= rx_word[DATA_W +: ADDR_W];
              wdata_reg <= rx_word[DATA_W-1:0];
            end
          end
        end
        REQ: begin
          // Rise strobes here are the master's idle bits and are not shifted.
          if (sel_n_s) begin
            req_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (ack_i) begin
            req_reg   <= 1'b0;
            tx_reg    <= {1'b1, wr_reg, cmd_reg, addr_reg, wr_reg ? wdata_reg : rdata_i};
            dly_reg   <= RSP_DELAY[DLY_W-1:0];
            cnt_reg   <= CNT_W'(FRAME_LEN);
            state_reg <= TX;
          end
        end
        TX: begin
          if (sel_n_s) begin
            rsp_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (fall) begin
            if (dly_reg != '0) begin
              dly_reg <= dly_reg - 1'b1;
            end else if (cnt_reg != '0) begin
              rsp_reg <= tx_reg[FRAME_LEN-1];
              tx_reg  <= {tx_reg[FRAME_LEN-2:0], 1'b0};
              cnt_reg <= cnt_reg - 1'b1;
            end else begin
              // Last bit has now been held for a full saci period.
              rsp_reg   <= 1'b0;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          rsp_reg <= 1'b0;
          if (sel_n_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign saci_rsp_o = rsp_reg;
  assign req_o      = req_reg;
  assign wr_o       = wr_reg;
  assign cmd_o      = cmd_reg;
  assign addr_o     = addr_reg;
  assign wdata_o    = wdata_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_saci_slave_oversampled.sv
// Bench for saci_slave_oversampled: a bit-banging master, a register core
// responder and a response monitor share expectation queues.
module tb_saci_slave_oversampled;

  localparam int HALF = 6;
  localparam int SYNC = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        saci_clk_i = 1'b0;
  logic        saci_sel_n_i = 1'b1;
  logic        saci_cmd_i = 1'b0;
  logic        saci_rsp_o;
  logic        req_o, wr_o, busy_o;
  logic [6:0]  cmd_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic        ack_i = 1'b0;
  logic [31:0] rdata_i = '0;

  saci_slave_oversampled #(.SYNC_STAGES(SYNC), .RSP_DELAY(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .saci_clk_i(saci_clk_i),
    .saci_sel_n_i(saci_sel_n_i), .saci_cmd_i(saci_cmd_i),
    .saci_rsp_o(saci_rsp_o), .req_o(req_o), .wr_o(wr_o), .cmd_o(cmd_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .ack_i(ack_i), .rdata_i(rdata_i),
    .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int rsp_done = 0;
  int mon_cnt = 0;

  logic [51:0] req_exp_q[$];
  logic [52:0] rsp_exp_q[$];
  logic [31:0] rdata_q[$];
  int          dly_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endtask

  // Core side: compares each request against the next expected one, then acks.
  initial begin : responder
    logic [51:0] e;
    logic [31:0] r;
    int d;
    forever begin
      @(negedge clk_i);
      if (req_o === 1'b1) begin
        if (req_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req got=req_o=1 exp=no request");
          ack_i = 1'b1;
          @(negedge clk_i);
          ack_i = 1'b0;
        end else begin
          e = req_exp_q.pop_front();
          d = dly_q.pop_front();
          r = rdata_q.pop_front();
          check("req_fields", 64'({wr_o, cmd_o, addr_o, wdata_o}), 64'(e));
          repeat (d) @(negedge clk_i);
          check("req_stable", 64'({req_o, wr_o, cmd_o, addr_o, wdata_o}), 64'({1'b1, e}));
          rdata_i = r;
          ack_i = 1'b1;
          @(negedge clk_i);
          ack_i = 1'b0;
          check("req_drop", 64'(req_o), 64'(0));
        end
      end
    end
  end

  // Master side sampling of the response line on saci clock rises.
  initial begin : rsp_monitor
    logic [52:0] w;
    logic inf;
    int n;
    inf = 1'b0;
    n = 0;
    w = '0;
    forever begin
      @(posedge saci_clk_i);
      if (saci_sel_n_i) begin
        inf = 1'b0;
        n = 0;
      end else if (!inf) begin
        if (saci_rsp_o === 1'b1) begin
          inf = 1'b1;
          w = 53'd1;
          n = 1;
        end
      end else begin
        w = {w[51:0], saci_rsp_o};
        n++;
        if (n == 53) begin
          if (rsp_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp got=%h exp=no response", w);
          end else begin
            check("rsp_frame", 64'(w), 64'(rsp_exp_q.pop_front()));
          end
          rsp_done++;
          inf = 1'b0;
          n = 0;
        end
      end
      mon_cnt = n;
    end
  end

  task automatic tick(input logic b);
    saci_cmd_i = b;
    repeat (HALF) @(posedge clk_i);
    #2 saci_clk_i = 1'b1;
    repeat (HALF) @(posedge clk_i);
    #2 saci_clk_i = 1'b0;
  endtask

  task automatic send_bits(input logic [52:0] f, input int n);
    for (int i = 0; i < n; i++) tick(f[52-i]);
  endtask

  // Reference model: what the core should see, and what the master should get back.
  task automatic queue_frame(input logic wr, input logic [6:0] cmd, input logic [11:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata, input int dly);
    req_exp_q.push_back({wr, cmd, addr, data});
    rdata_q.push_back(rdata);
    dly_q.push_back(dly);
    rsp_exp_q.push_back({1'b1, wr, cmd, addr, (wr ? data : rdata)});
  endtask

  task automatic run_frame(input logic wr, input logic [6:0] cmd, input logic [11:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int dly);
    int start;
    int n;
    start = rsp_done;
    queue_frame(wr, cmd, addr, data, rdata, dly);
    saci_sel_n_i = 1'b0;
    tick(1'b0);
    send_bits({1'b1, wr, cmd, addr, data}, 53);
    n = 0;
    while (rsp_done == start && n < 300) begin
      tick(1'b0);
      n++;
    end
    if (rsp_done == start) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout got=no response exp=response within 300 saci periods");
    end
    tick(1'b0);
    saci_sel_n_i = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("end_idle", 64'({busy_o, saci_rsp_o, req_o}), 64'(0));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [51:0] junk;
    int n;
    repeat (3) @(posedge clk_i);
    #1 check("reset_outputs",
             64'({req_o, wr_o, cmd_o, addr_o, wdata_o, saci_rsp_o, busy_o}), 64'(0));
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    tick(1'b0);
    tick(1'b0);

    run_frame(1'b1, 7'h05, 12'h123, 32'hDEADBEEF, $urandom, 3);
    run_frame(1'b0, 7'h7F, 12'hFFF, $urandom, 32'h0BADF00D, 2);

    // Aborted frame: sel_n raised after 20 command bits.
    junk = {$urandom, $urandom};
    saci_sel_n_i = 1'b0;
    tick(1'b0);
    send_bits({1'b1, junk}, 20);
    saci_sel_n_i = 1'b1;
    repeat (SYNC + 2) @(posedge clk_i);
    #1 check("abort_idle", 64'({busy_o, req_o, saci_rsp_o}), 64'(0));
    tick(1'b0);
    tick(1'b0);

    // Back-to-back frames.
    run_frame(1'b1, 7'($urandom), 12'($urandom), $urandom, $urandom, 1);
    run_frame(1'b0, 7'($urandom), 12'($urandom), $urandom, $urandom, 0);

    // Long ack delay while the master keeps clocking idle bits.
    run_frame(1'b0, 7'h2A, 12'h5A5, 32'hFFFFFFFF, 32'h13579BDF, 1000);

    for (int i = 0; i < 5; i++) begin
      run_frame(1'($urandom), 7'($urandom), 12'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 40)));
    end

    // Reset pulse in the middle of the response.
    queue_frame(1'b1, 7'h11, 12'h0F0, 32'hA5A5A5A5, $urandom, 2);
    saci_sel_n_i = 1'b0;
    tick(1'b0);
    send_bits({1'b1, 1'b1, 7'h11, 12'h0F0, 32'hA5A5A5A5}, 53);
    n = 0;
    while (mon_cnt < 10 && n < 300) begin
      tick(1'b0);
      n++;
    end
    if (mon_cnt < 10) begin
      total++;
      bad++;
      $display("FAIL tx_reach got=%0d bits exp=at least 10 bits", mon_cnt);
    end
    check("tx_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1 check("rst_in_tx",
             64'({req_o, wr_o, cmd_o, addr_o, wdata_o, saci_rsp_o, busy_o}), 64'(0));
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    if (rsp_exp_q.size() != 0) void'(rsp_exp_q.pop_front());
    saci_sel_n_i = 1'b1;
    tick(1'b0);
    tick(1'b0);
    run_frame(1'b0, 7'h33, 12'hABC, $urandom, 32'hCAFEF00D, 4);

    check("queues_drained", 64'(rsp_exp_q.size() + req_exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saci_slave_oversampled.md
SACI_SLAVE_OVERSAMPLED -- requirements
Module: saci_slave_oversampled

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for saci_clk_i, saci_sel_n_i and saci_cmd_i.
REQ-002 SHALL have parameter RSP_DELAY, default 0, extra saci_clk falling edges inserted between ack and response start bit.
REQ-003 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 saci_clk_i  in  1  SACI serial clock from master; asynchronous to clk_i.
REQ-006 saci_sel_n_i  in  1  active-low slave select.
REQ-007 saci_cmd_i  in  1  serial command line, MSB first.
REQ-008 saci_rsp_o  out  1  serial response line, MSB first.
REQ-009 req_o  out  1  register request, level, held until ack_i.
REQ-010 wr_o  out  1  1 = write, 0 = read; valid while req_o.
REQ-011 cmd_o  out  7  decoded command field; valid while req_o.
REQ-012 addr_o  out  12  decoded address field; valid while req_o.
REQ-013 wdata_o  out  32  decoded data field; valid while req_o.
REQ-014 ack_i  in  1  core acknowledge; sampled only while req_o = 1.
REQ-015 rdata_i  in  32  read data; captured on the cycle ack_i = 1.
REQ-016 busy_o  out  1  1 in any state other than IDLE.

Function
REQ-017 SHALL synchronize saci_clk_i, saci_sel_n_i and saci_cmd_i through SYNC_STAGES flops; one further register stage produces rise/fall strobes of the synchronized saci clock.
REQ-018 Frame SHALL be 53 bits: start(1) = 1, wr(1), cmd(7), addr(12), data(32).
REQ-019 Command bits SHALL be sampled on the synchronized saci clock rising strobe while synchronized sel_n = 0.
REQ-020 State IDLE: on rise strobe with sel_n = 0 and cmd = 1 SHALL load the bit counter with 52 and go to RX; cmd = 0 SHALL be ignored.
REQ-021 RX: each rise strobe SHALL shift cmd into a 52-bit register and decrement the counter; when the counter reaches 0, SHALL go to REQ and assert req_o on the following clk_i cycle.
REQ-022 REQ: req_o = 1 with stable fields; on ack_i = 1 SHALL latch response data (rdata_i if wr = 0, received data if wr = 1), deassert req_o the next cycle, and go to TX.
REQ-023 TX: after RSP_DELAY fall strobes, SHALL drive the 53-bit response {1, wr, cmd, addr, data} on saci_rsp_o, with each bit changing only on a fall strobe and the first bit (start) presented at the first fall strobe.
REQ-024 After the last response bit has been held for one full saci clock period, SHALL drive saci_rsp_o = 0 and go to DONE.
REQ-025 DONE SHALL wait for synchronized sel_n = 1, then go to IDLE.
REQ-026 saci_rsp_o SHALL be 0 in every state except TX.
REQ-027 Synchronized sel_n = 1 in RX, REQ or TX SHALL abort to IDLE within one clk_i cycle, deassert req_o and zero saci_rsp_o; an ack_i in that same cycle SHALL be ignored.
REQ-028 A rise strobe in REQ SHALL be ignored, because the master clocks idle bits while awaiting response.
REQ-029 Correct operation SHALL be guaranteed only when the saci_clk high and low phases are each at least SYNC_STAGES+2 clk_i cycles long.
REQ-030 Unused cmd codes SHALL still be forwarded; the block does no command decoding.

Reset
REQ-031 rst_i SHALL asynchronously force state IDLE, counter 0, all synchronizer flops to idle levels (saci_clk 0, sel_n 1, cmd 0), req_o 0, wr_o 0, cmd_o 0, addr_o 0, wdata_o 0, saci_rsp_o 0 and busy_o 0.
REQ-032 Reset release mid-frame SHALL wait for a fresh start bit; a partial frame in progress SHALL never be decoded.

Structure
REQ-033 The shared package saci_pkg SHALL hold the constants for the frame length (53) and the cmd, addr and data widths, plus the state enum {IDLE, RX, REQ, TX, DONE}.
REQ-034 The multi-flop synchronizer SHALL be a sub-module saci_sync, instantiated three times.

Verification
REQ-035 Write frame wr=1, cmd=0x05, addr=0x123, data=0xDEADBEEF, ack after 3 cycles -> req_o fields match; rsp = {1,1,0x05,0x123,0xDEADBEEF}.
REQ-036 Read frame wr=0, cmd=0x7F, addr=0xFFF, rdata_i=0x0BADF00D -> rsp data field = 0x0BADF00D; wdata_o = received data field.
REQ-037 sel_n raised after 20 command bits -> IDLE within SYNC_STAGES+2 cycles, req_o never asserted, rsp 0.
REQ-038 Two back-to-back frames with sel_n high for 2 saci periods between them -> both decoded and both responses correct.
REQ-039 rst_i pulsed during TX -> all outputs at reset values immediately; next full frame decodes correctly.
REQ-040 Delay ack_i by 1000 cycles while the master clocks idle bits -> no extra bits are shifted in, and the response is unchanged after ack.
